spike_step_scheduler: RTL and testbench

SPIKE_STEP_SCHEDULER -- requirements
Module: spike_step_scheduler

---
 rtl/snn_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/spike_step_scheduler.sv | 170 +++++++++++++++++
 tb/tb_spike_step_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types and default sizing for the spike step scheduler.
package snn_sched_pkg;

   localparam int N_REQ_DEF         = 4;
   localparam int TSTEP_CYCLES_DEF  = 16;
   localparam int REFRACT_STEPS_DEF = 4;
   localparam int ISYN_MAX          = 255;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_REFRACT = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arbiter
   import snn_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant
);

   logic found;
   int   idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spike_step_scheduler.sv
// Collects synaptic weights per timestep window and issues the saturated sum as isyn.
// Define SPIKE_SCHED_REFRACTORY_EN to build the post-spike refractory state.
module spike_step_scheduler
   import snn_sched_pkg::*;
#(
   parameter int N_REQ         = N_REQ_DEF,
   parameter int TSTEP_CYCLES  = TSTEP_CYCLES_DEF,
   parameter int REFRACT_STEPS = REFRACT_STEPS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_weight,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 spike,
   output logic [7:0]           isyn,
   output logic                 isyn_valid,
   output logic                 in_refract
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'(ISYN_MAX) : s[7:0];
   endfunction

   state_e           state_q, state_d;
   logic [7:0]       wcnt_q, wcnt_d;
   logic [7:0]       acc_q, acc_d;
   logic [PTR_W-1:0] rr_q, rr_d;
   logic [7:0]       isyn_q, isyn_d;
   logic             isyn_valid_q, isyn_valid_d;

   logic [N_REQ-1:0] grant;
   logic             xfer;
   logic [7:0]       xfer_w;
   logic [7:0]       acc_sum;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] rr_next;
   logic             win_last;

   rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
      .req   (req_valid),
      .ptr   (rr_q),
      .grant (grant)
   );

   assign req_ready = (!reset && state_q != ST_ISSUE) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);
   assign win_last  = (wcnt_q == 8'(TSTEP_CYCLES - 1));
   assign acc_sum   = xfer ? sat_add(acc_q, xfer_w) : acc_q;

   always_comb begin
      xfer_w    = '0;
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            xfer_w    = req_weight[8*i +: 8];
            grant_idx = PTR_W'(i);
         end
      end
      rr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

`ifdef SPIKE_SCHED_REFRACTORY_EN
   logic [3:0] rcnt_q, rcnt_d;
   logic       spike_seen_q, spike_seen_d;
   assign in_refract = (state_q == ST_REFRACT);
`else
   logic unused_spike;
   assign unused_spike = spike;
   assign in_refract   = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      acc_d        = acc_q;
      rr_d         = xfer ? rr_next : rr_q;
      isyn_d       = isyn_q;
      isyn_valid_d = 1'b0;
`ifdef SPIKE_SCHED_REFRACTORY_EN
      rcnt_d       = rcnt_q;
      spike_seen_d = spike_seen_q;
`endif
      case (state_q)
         ST_COLLECT: begin
`ifdef SPIKE_SCHED_REFRACTORY_EN
            spike_seen_d = spike_seen_q | spike;
`endif
            // isyn is loaded on the way into ISSUE so the strobe is visible during ISSUE
            if (win_last) begin
               state_d      = ST_ISSUE;
               isyn_d       = acc_sum;
               isyn_valid_d = 1'b1;
               acc_d        = '0;
               wcnt_d       = '0;
            end else begin
               acc_d  = acc_sum;
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         ST_ISSUE: begin
            state_d = ST_COLLECT;
`ifdef SPIKE_SCHED_REFRACTORY_EN
            if (spike_seen_q || spike) begin
               state_d = ST_REFRACT;
               rcnt_d  = '0;
            end
            spike_seen_d = 1'b0;
`endif
         end
`ifdef SPIKE_SCHED_REFRACTORY_EN
         ST_REFRACT: begin
            acc_d = '0;
            if (win_last) begin
               wcnt_d       = '0;
               isyn_d       = '0;
               isyn_valid_d = 1'b1;
               if (rcnt_q == 4'(REFRACT_STEPS - 1)) begin
                  state_d = ST_COLLECT;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q + 4'd1;
               end
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
`endif
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_COLLECT;
         wcnt_q       <= '0;
         acc_q        <= '0;
         rr_q         <= '0;
         isyn_q       <= '0;
         isyn_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         acc_q        <= acc_d;
         rr_q         <= rr_d;
         isyn_q       <= isyn_d;
         isyn_valid_q <= isyn_valid_d;
      end
   end

`ifdef SPIKE_SCHED_REFRACTORY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt_q       <= '0;
         spike_seen_q <= 1'b0;
      end else begin
         rcnt_q       <= rcnt_d;
         spike_seen_q <= spike_seen_d;
      end
   end
`endif

   assign isyn       = isyn_q;
   assign isyn_valid = isyn_valid_q;

endmodule

// File: tb/tb_spike_step_scheduler.sv
// Self-checking bench: directed window table, corner sequences, randomized run vs window-level model.
module tb_spike_step_scheduler;

   localparam int N  = 4;
   localparam int TS = 16;
   localparam int RS = 4;
`ifdef SPIKE_SCHED_REFRACTORY_EN
   localparam bit REFR = 1'b1;
`else
   localparam bit REFR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [8*N-1:0]   req_weight;
   logic [N-1:0]     req_ready;
   logic             spike;
   logic [7:0]       isyn;
   logic             isyn_valid;
   logic             in_refract;

   spike_step_scheduler #(.N_REQ(N), .TSTEP_CYCLES(TS), .REFRACT_STEPS(RS)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_weight (req_weight),
      .req_ready  (req_ready),
      .spike      (spike),
      .isyn       (isyn),
      .isyn_valid (isyn_valid),
      .in_refract (in_refract)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Window-level reference: the raw sum is clipped once at issue time.
   int m_t, m_refr, m_sum, m_rr, m_isyn;
   bit m_issuing, m_seen, m_valid;

   function automatic void m_reset();
      m_t = 0; m_refr = 0; m_sum = 0; m_rr = 0; m_isyn = 0;
      m_issuing = 0; m_seen = 0; m_valid = 0;
   endfunction

   function automatic int m_grant(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(m_rr + k) % N]) return (m_rr + k) % N;
      end
      return -1;
   endfunction

   function automatic void m_step(input logic [N-1:0] v, input logic [8*N-1:0] w, input logic s);
      int g;
      bit nv;
      nv = 0;
      if (m_issuing) begin
         m_issuing = 0;
         if (REFR && (m_seen || s)) m_refr = RS;
         m_seen = 0;
      end else begin
         g = m_grant(v);
         if (g >= 0) begin
            m_rr = (g + 1) % N;
            if (m_refr == 0) m_sum += int'(w[8*g +: 8]);
         end
         if (REFR && m_refr == 0 && s) m_seen = 1;
         if (m_t == TS - 1) begin
            m_t = 0;
            nv  = 1;
            if (m_refr == 0) begin
               m_issuing = 1;
               m_isyn = (m_sum > 255) ? 255 : m_sum;
               m_sum = 0;
            end else begin
               m_isyn = 0;
               m_refr--;
            end
         end else begin
            m_t++;
         end
      end
      m_valid = nv;
   endfunction

   task automatic cycle(input logic [N-1:0] v, input logic [8*N-1:0] w, input logic s, input logic r);
      int g;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      req_valid = v; req_weight = w; spike = s; reset = r;
      #1;
      g = m_grant(v);
      exp_rdy = (r || m_issuing || g < 0) ? '0 : (N'(1) << g);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("isyn", 32'(isyn), 32'(m_isyn));
      chk("isyn_valid", 32'(isyn_valid), 32'(m_valid));
      chk("in_refract", 32'(in_refract), 32'(m_refr > 0));
      if (r) m_reset();
      else   m_step(v, w, s);
   endtask

   typedef struct {
      logic [N-1:0]   v;
      logic [8*N-1:0] w;
      int             exp_isyn;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int refr_cnt, strobe_cnt, ack_cnt;
      tbl[0] = '{v: 4'b0001, w: {8'd0, 8'd0, 8'd0, 8'd10},     exp_isyn: 160};
      tbl[1] = '{v: 4'b1111, w: {8'd4, 8'd3, 8'd2, 8'd1},      exp_isyn: 40};
      tbl[2] = '{v: 4'b0011, w: {8'd0, 8'd0, 8'd200, 8'd200},  exp_isyn: 255};
      tbl[3] = '{v: 4'b0000, w: {8'd9, 8'd9, 8'd9, 8'd9},      exp_isyn: 0};
      tbl[4] = '{v: 4'b0100, w: {8'd0, 8'd255, 8'd0, 8'd0},    exp_isyn: 255};
      tbl[5] = '{v: 4'b1010, w: {8'd5, 8'd0, 8'd3, 8'd0},      exp_isyn: 64};
      tbl[6] = '{v: 4'b1111, w: {8'd1, 8'd1, 8'd1, 8'd1},      exp_isyn: 16};

      reset = 1'b1; req_valid = '0; req_weight = '0; spike = 1'b0;
      repeat (2) @(posedge clk);
      m_reset();
      cycle('0, '0, 1'b0, 1'b1);
      cycle(4'b1111, '0, 1'b0, 1'b1);

      // Directed windows: 16 collect cycles plus the ISSUE cycle after a fresh reset
      for (int e = 0; e < 7; e++) begin
         cycle('0, '0, 1'b0, 1'b1);
         for (int c = 0; c <= TS; c++) begin
            cycle(tbl[e].v, tbl[e].w, 1'b0, 1'b0);
            if (c == TS) begin
               chk("tbl_isyn", 32'(isyn), 32'(tbl[e].exp_isyn));
               chk("tbl_strobe", 32'(isyn_valid), 32'd1);
            end
         end
      end
      for (int c = 0; c < 17; c++) begin
         cycle(4'b0001, {24'd0, 8'd10}, 1'b0, 1'b0);
         if (c == 16) chk("second_strobe_17", 32'(isyn_valid), 32'd1);
      end

      // Transfer in the final COLLECT cycle
      cycle('0, '0, 1'b0, 1'b1);
      for (int c = 0; c < TS - 1; c++) cycle('0, '0, 1'b0, 1'b0);
      cycle(4'b0001, {24'd0, 8'd7}, 1'b0, 1'b0);
      cycle(4'b0001, {24'd0, 8'd7}, 1'b0, 1'b0);
      chk("last_cycle_isyn", 32'(isyn), 32'd7);
      chk("issue_no_ready", 32'(req_ready), 32'd0);

      // Reset mid-window drops partial accumulation
      cycle('0, '0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) cycle(4'b0001, {24'd0, 8'd10}, 1'b0, 1'b0);
      for (int c = 5; c < 9; c++) cycle('0, '0, 1'b0, 1'b0);
      cycle(4'b0001, {24'd0, 8'd10}, 1'b0, 1'b1);
      chk("reset_no_ready", 32'(req_ready), 32'd0);
      for (int c = 0; c <= TS; c++) begin
         cycle(4'b0001, {24'd0, 8'd1}, 1'b0, 1'b0);
         if (c < TS) chk("isyn_zero_pre_strobe", 32'(isyn), 32'd0);
         else        chk("post_reset_isyn", 32'(isyn), 32'd16);
      end

      // Spike at wcnt=5: refractory windows when built, ignored otherwise
      cycle('0, '0, 1'b0, 1'b1);
      for (int c = 0; c <= TS; c++) cycle(4'b0001, {24'd0, 8'd10}, c == 5, 1'b0);
      refr_cnt = 0; strobe_cnt = 0; ack_cnt = 0;
      for (int c = 0; c < RS * TS + 1; c++) begin
         cycle(4'b0001, {24'd0, 8'd10}, c == 3, 1'b0);
         if (in_refract) refr_cnt++;
         if (in_refract && req_ready[0]) ack_cnt++;
         if (isyn_valid && REFR) begin
            strobe_cnt++;
            chk("refract_strobe_isyn", 32'(isyn), 32'd0);
         end
      end
      chk("refract_cycles", 32'(refr_cnt), REFR ? 32'(RS * TS) : 32'd0);
      chk("refract_acks", 32'(ack_cnt), REFR ? 32'(RS * TS) : 32'd0);
      if (REFR) chk("refract_strobes", 32'(strobe_cnt), 32'(RS));
      for (int c = 0; c < TS + 1; c++) cycle(4'b0001, {24'd0, 8'd10}, 1'b0, 1'b0);

      // Randomized traffic, spikes and occasional resets
      for (int c = 0; c < 1500; c++) begin
         cycle(N'($urandom_range(0, 15)), $urandom, $urandom_range(0, 24) == 0,
               $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
